ifetch_queue: RTL and testbench

//  Instruction fetch front end: owns the program counter, drives the byte address

---
 rtl/ifetch_queue_if.sv | 37 +++
 rtl/ifetch_queue.sv | 99 +++++++++
 tb/tb_ifetch_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction memory port, redirect
// input and the valid/ready stream towards decode.
interface ifetch_queue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  fault
  );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch front end: PC register, combinational imem port
// and a small {pc, instr} queue feeding decode.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_BYTES = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_queue_if.master bus
);
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL   = DEPTH[AW:0];
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [32:0] PC_MAX =
    {1'b0, IMEM_BYTES[31:0] - 32'd4};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic          fault_q, fault_d;
  logic          push, pop, valid;
  logic [32:0]   pc_inc;

  // 33-bit check so a wrap past 2^32 still counts as out of range
  function automatic logic bad_pc(input logic [32:0] a);
    return (a[1:0] != 2'b00) || (a > PC_MAX);
  endfunction

  assign valid  = (cnt_q != '0);
  assign pop    = valid & bus.out_ready;
  assign push   = ~fault_q & ~bus.redirect_valid &
                  ((cnt_q < FULL) | pop);
  assign pc_inc = {1'b0, pc_q} + 33'd4;

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    unique case (1'b1)
      bus.redirect_valid: begin
        pc_d    = bus.redirect_pc;
        cnt_d   = '0;
        rd_d    = '0;
        wr_d    = '0;
        fault_d = bad_pc({1'b0, bus.redirect_pc});
      end
      default: begin
        if (push) begin
          pc_d    = pc_inc[31:0];
          wr_d    = wr_q + 1'b1;
          fault_d = bad_pc(pc_inc);
        end
        if (pop) begin
          rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, push}
                      - {{AW{1'b0}}, pop};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_q] <= '{pc: pc_q, instr: bus.imem_rdata};
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? q_mem[rd_q].pc : 32'h0;
  assign bus.out_instr = valid ? q_mem[rd_q].instr : NOP;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model
// checked every cycle plus directed literal expectations.
module tb_ifetch_queue;
  localparam int DEPTH = 2;
  localparam int IMEM  = 4096;

  logic clk;
  logic rst_n;
  ifetch_queue_if bus ();

  ifetch_queue #(
    .RESET_PC  (32'h0),
    .DEPTH     (DEPTH),
    .IMEM_BYTES(IMEM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    case (a)
      32'h000: return 32'h0090_0493;
      32'h004: return 32'h0050_0293;
      32'h008: return 32'hFE54_AE23;
      32'h018: return 32'hFE42_0AE3;
      32'hFFC: return 32'hDEAD_BEEF;
      default: return 32'h1000_0000 ^ a;
    endcase
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc    = 32'h0;
  bit          m_fault = 1'b0;

  function automatic bit illegal(input longint unsigned a);
    return (a % 4 != 0) || (a > IMEM - 4);
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int  sz;
      bit  pp;
      bit  ps;
      sz = mq.size();
      pp = (sz != 0) && bus.out_ready;
      if (bus.redirect_valid) begin
        mq.delete();
        m_pc    = bus.redirect_pc;
        m_fault = illegal(longint'(bus.redirect_pc));
      end else begin
        ps = !m_fault && (sz < DEPTH || pp);
        if (pp) void'(mq.pop_front());
        if (ps) begin
          mq.push_back('{m_pc, mem_word(m_pc)});
          m_fault = illegal(longint'(m_pc) + 4);
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ep, ei;
    ev = (mq.size() != 0);
    ep = ev ? mq[0].pc : 32'h0;
    ei = ev ? mq[0].instr : 32'h13;
    chk("m_valid", {31'b0, bus.out_valid}, {31'b0, ev});
    chk("m_pc", bus.out_pc, ep);
    chk("m_instr", bus.out_instr, ei);
    chk("m_addr", bus.imem_addr, m_pc);
    chk("m_fault", {31'b0, bus.fault}, {31'b0, m_fault});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    cyc();
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] rdy_pat;

  initial begin
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    cyc();
    cyc();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_fault", {31'b0, bus.fault}, 32'd0);
    chk("rst_instr", bus.out_instr, 32'h13);

    // 1: streaming from reset
    rst_n = 1'b1;
    cyc();
    chk("t1_pc0", bus.out_pc, 32'h0);
    chk("t1_in0", bus.out_instr, 32'h0090_0493);
    cyc();
    chk("t1_pc1", bus.out_pc, 32'h4);
    chk("t1_in1", bus.out_instr, 32'h0050_0293);
    cyc();
    chk("t1_pc2", bus.out_pc, 32'h8);
    chk("t1_in2", bus.out_instr, 32'hFE54_AE23);

    // 2: backpressure from release
    rst_n = 1'b0;
    cyc();
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("t2_addr", bus.imem_addr, 32'h8);
    chk("t2_pc0", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
    chk("t2_pc1", bus.out_pc, 32'h4);
    cyc();
    chk("t2_pc2", bus.out_pc, 32'h8);
    cyc();
    chk("t2_pc3", bus.out_pc, 32'hC);

    // 3: redirect with a full queue
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    redir(32'h18);
    chk("t3_bub", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("t3_pc", bus.out_pc, 32'h18);
    chk("t3_in", bus.out_instr, 32'hFE42_0AE3);

    // 4: misaligned target, then recover
    bus.out_ready = 1'b1;
    redir(32'h1A);
    chk("t4_flt", {31'b0, bus.fault}, 32'd1);
    chk("t4_val", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("t4_hold", bus.imem_addr, 32'h1A);
    chk("t4_val2", {31'b0, bus.out_valid}, 32'd0);
    redir(32'h0);
    chk("t4_clr", {31'b0, bus.fault}, 32'd0);
    cyc();
    chk("t4_pc", bus.out_pc, 32'h0);
    chk("t4_val3", {31'b0, bus.out_valid}, 32'd1);

    // irregular ready pattern exercises push+pop when full
    rdy_pat = 32'b1011_0010_0111_0001_1100_1010_0110_1101;
    for (int i = 0; i < 32; i++) begin
      bus.out_ready = rdy_pat[i];
      cyc();
    end
    bus.out_ready = 1'b1;

    // 5: last legal word, then fault on +4
    redir(32'hFFC);
    chk("t5_addr", bus.imem_addr, 32'hFFC);
    chk("t5_f0", {31'b0, bus.fault}, 32'd0);
    cyc();
    chk("t5_pc", bus.out_pc, 32'hFFC);
    chk("t5_in", bus.out_instr, 32'hDEAD_BEEF);
    chk("t5_f1", {31'b0, bus.fault}, 32'd1);
    chk("t5_addr2", bus.imem_addr, 32'h1000);
    cyc();
    chk("t5_empty", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    chk("t5_empty2", {31'b0, bus.out_valid}, 32'd0);

    // wrap past 2^32 must still fault
    redir(32'hFFFF_FFFC);
    chk("wrap_flt", {31'b0, bus.fault}, 32'd1);

    // 6: asynchronous reset with a full queue
    redir(32'h0);
    bus.out_ready = 1'b0;
    repeat (4) cyc();
    chk("t6_full", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_pc", bus.out_pc, 32'h0);
    chk("t6_val", {31'b0, bus.out_valid}, 32'd1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
